// File: rtl/row_access_sched.sv
// rtl/row_access_sched.sv - row decoder access sequencer and read/write/refresh arbiter
//
// Arbitrates read, write and timed refresh accesses to a 2**ROW_BITS row decoder
// and sequences each access as SETUP / ACTIVE / RECOVER so the address is stable
// at least one cycle either side of the wordline enable.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   refresh_en           enables the refresh timer
//   rd_req, rd_row       read request (held until rd_ack) and row
//   rd_ack               one-cycle completion pulse for a read
//   wr_req, wr_row       write request (held until wr_ack) and row
//   wr_ack               one-cycle completion pulse for a write
//   row_addr, row_en     registered decoder address and enable
//   ref_active           a refresh access is in SETUP, ACTIVE or RECOVER
//   ref_row              next row to be refreshed
//   busy                 sequencer is not idle
module row_access_sched #(
  parameter int ROW_BITS         = 5,
  parameter int ACT_CYCLES       = 2,
  parameter int REFRESH_INTERVAL = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                refresh_en,
  input  logic                rd_req,
  input  logic [ROW_BITS-1:0] rd_row,
  output logic                rd_ack,
  input  logic                wr_req,
  input  logic [ROW_BITS-1:0] wr_row,
  output logic                wr_ack,
  output logic [ROW_BITS-1:0] row_addr,
  output logic                row_en,
  output logic                ref_active,
  output logic [ROW_BITS-1:0] ref_row,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, SETUP, ACTIVE, RECOVER} state_t;
  typedef enum logic [1:0] {SRC_RD, SRC_WR, SRC_REF} src_t;

  localparam int CW = (ACT_CYCLES > 1) ? $clog2(ACT_CYCLES) : 1;
  localparam int TW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam logic [CW-1:0] ACT_LAST = CW'(ACT_CYCLES - 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(REFRESH_INTERVAL - 1);

  state_t        state, state_next;
  src_t          src, src_next;
  logic          accept;
  logic [CW-1:0] act_cnt;
  logic [TW-1:0] timer;
  logic          ref_pending;
  logic          last_wr;   // last rd/wr grant went to the write port

  always_comb begin
    state_next = state;
    src_next   = src;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (ref_pending) begin
          accept   = 1'b1;
          src_next = SRC_REF;
        end else if (rd_req && (!wr_req || last_wr)) begin
          accept   = 1'b1;
          src_next = SRC_RD;
        end else if (wr_req) begin
          accept   = 1'b1;
          src_next = SRC_WR;
        end
        if (accept) state_next = SETUP;
      end
      SETUP:   state_next = ACTIVE;
      ACTIVE:  if (act_cnt == ACT_LAST) state_next = RECOVER;
      RECOVER: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so the decoder sees
  // glitch-free strobes aligned with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      src         <= SRC_RD;
      act_cnt     <= '0;
      timer       <= '0;
      ref_pending <= 1'b0;
      last_wr     <= 1'b1;
      row_addr    <= '0;
      row_en      <= 1'b0;
      rd_ack      <= 1'b0;
      wr_ack      <= 1'b0;
      ref_active  <= 1'b0;
      busy        <= 1'b0;
      ref_row     <= '0;
    end else begin
      state <= state_next;
      src   <= src_next;

      if (state == ACTIVE && state_next == ACTIVE) act_cnt <= act_cnt + 1'b1;
      else                                         act_cnt <= '0;

      if (accept) begin
        case (src_next)
          SRC_RD:  row_addr <= rd_row;
          SRC_WR:  row_addr <= wr_row;
          default: row_addr <= ref_row;
        endcase
        if (src_next != SRC_REF) last_wr <= (src_next == SRC_WR);
      end

      row_en     <= (state_next == ACTIVE);
      rd_ack     <= (state_next == RECOVER) && (src_next == SRC_RD);
      wr_ack     <= (state_next == RECOVER) && (src_next == SRC_WR);
      ref_active <= (state_next != IDLE) && (src_next == SRC_REF);
      busy       <= (state_next != IDLE);

      if (state == RECOVER && src == SRC_REF) ref_row <= ref_row + 1'b1;

      // Acceptance clearing wins over a coincident terminal count, so a
      // pending refresh never stacks a second one behind it.
      if (!refresh_en) begin
        timer       <= '0;
        ref_pending <= 1'b0;
      end else begin
        timer <= (timer == TMR_LAST) ? '0 : timer + 1'b1;
        if (accept && src_next == SRC_REF) ref_pending <= 1'b0;
        else if (timer == TMR_LAST)        ref_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_row_access_sched.sv
// tb/tb_row_access_sched.sv - randomized self-checking bench for row_access_sched
module tb_row_access_sched;

  localparam int RB = 5;
  localparam int A  = 2;
  localparam int RI = 64;
  localparam int NROWS = 1 << RB;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          refresh_en;
  logic          rd_req, wr_req;
  logic [RB-1:0] rd_row, wr_row;
  logic          rd_ack, wr_ack, row_en, ref_active, busy;
  logic [RB-1:0] row_addr, ref_row;

  row_access_sched #(.ROW_BITS(RB), .ACT_CYCLES(A), .REFRESH_INTERVAL(RI)) dut (
    .clk(clk), .rst_n(rst_n), .refresh_en(refresh_en),
    .rd_req(rd_req), .rd_row(rd_row), .rd_ack(rd_ack),
    .wr_req(wr_req), .wr_row(wr_row), .wr_ack(wr_ack),
    .row_addr(row_addr), .row_en(row_en), .ref_active(ref_active),
    .ref_row(ref_row), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: m_pos is the position inside the current access
  // (0 idle, 1 setup, 2..A+1 enable window, A+2 recover); m_src 0=rd 1=wr 2=ref.
  int m_pos, m_src, m_addr, m_ref_row, m_timer;
  bit m_pend, m_last_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_src = 0; m_addr = 0; m_ref_row = 0; m_timer = 0;
    m_pend = 0; m_last_rd = 0;
  endtask

  task automatic model_step();
    bit took_ref;
    took_ref = 0;
    if (m_pos == 0) begin
      if (m_pend) begin
        m_src = 2; m_addr = m_ref_row; m_pos = 1; took_ref = 1;
      end else if (rd_req && (!wr_req || !m_last_rd)) begin
        m_src = 0; m_addr = rd_row; m_pos = 1; m_last_rd = 1;
      end else if (wr_req) begin
        m_src = 1; m_addr = wr_row; m_pos = 1; m_last_rd = 0;
      end
    end else if (m_pos == A + 2) begin
      if (m_src == 2) m_ref_row = (m_ref_row + 1) % NROWS;
      m_pos = 0;
    end else begin
      m_pos++;
    end
    if (!refresh_en) begin
      m_timer = 0; m_pend = 0;
    end else begin
      if (took_ref) m_pend = 0;
      else if (m_timer == RI - 1) m_pend = 1;
      m_timer = (m_timer + 1) % RI;
    end
  endtask

  function automatic bit exp_ack(input int src);
    return (m_pos == A + 2) && (m_src == src);
  endfunction

  task automatic compare_all();
    check("row_en",     row_en,     (m_pos >= 2 && m_pos <= A + 1));
    check("row_addr",   row_addr,   m_addr);
    check("rd_ack",     rd_ack,     exp_ack(0));
    check("wr_ack",     wr_ack,     exp_ack(1));
    check("ref_active", ref_active, (m_pos != 0 && m_src == 2));
    check("ref_row",    ref_row,    m_ref_row);
    check("busy",       busy,       (m_pos != 0));
  endtask

  // mode 0: finish outstanding requests, raise none; 1: random; 2: continuous rd/wr rows 3/30
  task automatic drive(input int mode);
    if (mode == 2) begin
      rd_req = 1; rd_row = 3; wr_req = 1; wr_row = 30;
      return;
    end
    if (rd_req) begin
      if (exp_ack(0)) begin
        rd_req = (mode == 1) && ($urandom_range(1, 0) == 1);
        rd_row = RB'($urandom);
      end
    end else if (mode == 1 && $urandom_range(3, 0) == 0) begin
      rd_req = 1; rd_row = RB'($urandom);
    end
    if (wr_req) begin
      if (exp_ack(1)) begin
        wr_req = (mode == 1) && ($urandom_range(1, 0) == 1);
        wr_row = RB'($urandom);
      end
    end else if (mode == 1 && $urandom_range(3, 0) == 0) begin
      wr_req = 1; wr_row = RB'($urandom);
    end
    if (mode == 1) begin
      if (refresh_en && $urandom_range(399, 0) == 0) refresh_en = 0;
      else if (!refresh_en && $urandom_range(9, 0) == 0) refresh_en = 1;
    end
  endtask

  task automatic cycle(input int mode);
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
    drive(mode);
  endtask

  initial begin
    rst_n = 0; refresh_en = 0;
    rd_req = 0; wr_req = 0; rd_row = 0; wr_row = 0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    rst_n = 1;

    // single read of row 13
    rd_req = 1; rd_row = 13;
    repeat (12) cycle(0);

    // refresh only: ref_row walks through all rows and wraps
    refresh_en = 1;
    repeat (2200) cycle(0);

    // rd/wr contention without refresh
    refresh_en = 0;
    repeat (40) cycle(2);
    repeat (12) cycle(0);

    // mixed random traffic with refresh
    refresh_en = 1;
    repeat (3000) cycle(1);
    repeat (12) cycle(0);

    // reset in the middle of a write to row 7
    refresh_en = 0;
    repeat (8) cycle(0);
    wr_req = 1; wr_row = 7;
    for (int i = 0; i < 20 && m_pos != 2; i++) cycle(0);
    check("reached_active", m_pos, 2);
    rst_n = 0;
    #1;
    check("rst_row_en", row_en, 0);
    check("rst_row_addr", row_addr, 0);
    check("rst_wr_ack", wr_ack, 0);
    check("rst_busy", busy, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    repeat (12) cycle(0);
    check("wr_req_done", wr_req, 0);

    // refresh_en dropped while a refresh is pending, then restarted
    refresh_en = 1;
    for (int i = 0; i < 80 && !m_pend; i++) cycle(0);
    check("pend_seen", m_pend, 1);
    refresh_en = 0;
    repeat (5) cycle(0);
    refresh_en = 1;
    repeat (140) cycle(0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/row_access_sched.md
# row_access_sched

Sequencer and arbiter for the 5-to-32 row decoder. It accepts row-access requests from a read port and a write port, plus internally timed refresh accesses. Each access drives the decoder's 5-bit row address and gates its enable with a setup / active / recover sequence, so only one wordline is ever asserted and it is never asserted while the address is changing. The block sits between the array control logic and the row decoder.

## Interface
- ROW_BITS, 5, row address width; the decoder drives 2**ROW_BITS rows.
- ACT_CYCLES, 2, cycles `row_en` stays high per access; legal range ≥1.
- REFRESH_INTERVAL, 64, clock cycles between refresh requests; legal range ≥4.

- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- refresh_en  in  1  enables the refresh timer.
- rd_req  in  1  read-port access request; held until `rd_ack`.
- rd_row  in  ROW_BITS  read row; sampled at acceptance.
- rd_ack  out  1  one-cycle pulse when the read access completes.
- wr_req  in  1  write-port access request; held until `wr_ack`.
- wr_row  in  ROW_BITS  write row; sampled at acceptance.
- wr_ack  out  1  one-cycle pulse when the write access completes.
- row_addr  out  ROW_BITS  registered address to the decoder.
- row_en  out  1  registered decoder enable (wordline strobe).
- ref_active  out  1  high while a refresh access occupies SETUP, ACTIVE or RECOVER.
- ref_row  out  ROW_BITS  next row to be refreshed.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- **States:** IDLE, SETUP, ACTIVE, RECOVER.
  - IDLE → SETUP when any of `ref_pending`, `rd_req` or `wr_req` is set; otherwise stay in IDLE.
  - SETUP → ACTIVE always.
  - ACTIVE → RECOVER after ACT_CYCLES cycles in ACTIVE.
  - RECOVER → IDLE always.
- **Arbitration** happens only in IDLE.
  - Priority order: `ref_pending` first, then rd/wr round-robin.
  - Round-robin uses a `last` bit, reset to "write", so read wins the first tie.
  - `last` updates only on rd/wr grants; refresh grants leave it unchanged.
- **Acceptance:** in the IDLE→SETUP transition, the winning row is latched into `row_addr`.
  - Winner is `rd_row`, `wr_row` or `ref_row`.
  - The source is recorded for the whole access.
- **row_en** is 1 only in ACTIVE. `row_addr` is stable from SETUP through RECOVER.
- **Completion:** in RECOVER, the ack of the recorded source pulses for exactly 1 cycle.
  - Refresh accesses produce no ack.
  - A refresh access increments `ref_row` on leaving RECOVER, wrapping 31 → 0.
- **Requester rules:**
  - `req` and `row` must be held until ack.
  - `req` still high in the cycle after ack counts as a new request.
  - Dropping `req` before ack is illegal; the access still completes and still acks.
- **Refresh timer:**
  - Counts 0..REFRESH_INTERVAL-1 while `refresh_en`=1.
  - At terminal count it wraps to 0 and sets `ref_pending`.
  - `ref_pending` clears on refresh acceptance.
  - A terminal count while `ref_pending` is already set is absorbed; refreshes do not accumulate.
  - `refresh_en`=0 holds the timer at 0 and clears `ref_pending`. A refresh access already in flight completes normally.
- **Reset** (any time, including mid-access) immediately forces:
  - state=IDLE, `row_en`=0, `row_addr`=0, `rd_ack`=`wr_ack`=0;
  - `ref_active`=0, `busy`=0, `ref_row`=0;
  - timer=0, `ref_pending`=0, `last`=write.
  - An interrupted access produces no ack.

## Timing
- Access length: 1 IDLE (arbitration) + 1 SETUP + ACT_CYCLES ACTIVE + 1 RECOVER.
  - That is ACT_CYCLES+3 cycles from the request being seen to the next arbitration.
  - Minimum request-to-ack latency (request present in IDLE at edge 0): `row_en` rises after edge 2 and the ack is high after edge ACT_CYCLES+2.
- Back-to-back throughput: one access per ACT_CYCLES+3 cycles (5 at default).
- Guaranteed `row_addr` setup and hold around the enable: at least 1 cycle each side of `row_en`.
- Refresh starvation bound: a pending refresh is accepted within ACT_CYCLES+3 cycles of `ref_pending` rising.
- rd/wr starvation bound with both requesting continuously: each port gets every other grant, excluding refresh grants.

## Test plan
- **Single read:** `rd_req`=1, `rd_row`=13 → `row_addr`=13 and `row_en` high for exactly 2 cycles. `rd_ack` is one pulse, 4 cycles after acceptance. `wr_ack` stays 0.
- **Contention:** `rd_req` and `wr_req` held continuously, rows 3 and 30, `refresh_en`=0 → grant order rd, wr, rd, wr. `row_addr` never changes while `row_en`=1.
- **Refresh:** `refresh_en`=1 with no requests → one refresh every 64 cycles. `ref_row` visits 0, 1, …, 31, then wraps to 0. `ref_active` is high 4 cycles per refresh. No acks are issued.
- **Refresh priority:** `ref_pending` set in the same cycle as `rd_req` → refresh of the current `ref_row` runs first, then the read; `rd_ack` follows within 10 cycles. A second terminal count during a long stall yields only one refresh.
- **Reset mid-ACTIVE** (during a write to row 7) → `row_en`=0 and `row_addr`=0 asynchronously. No `wr_ack`. After release with `wr_req` still high, the write restarts and acks normally.
- **refresh_en dropped** while `ref_pending`=1 → no refresh issued. Timer restarts from 0 when `refresh_en` returns, giving the first refresh 64 cycles later.
